// File: rtl/rf_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter_if
// Bundle of the writeback request ports, the scoreboard issue/query ports and
// the register file write port served by rf_wb_arbiter.
//   a_*          : port A writeback request (ALU/CSR), valid/ready handshake
//   b_*          : port B writeback request (load unit), valid/ready handshake
//   issue_*      : destination of the instruction issuing this cycle
//   flush        : scoreboard clear on pipeline redirect
//   rs1/rs2      : scoreboard query indices, busy_rs1/busy_rs2 results
//   wb_*         : registered register file write port
// Modports: slave = arbiter side, master = pipeline/register-file side.
// ----------------------------------------------------------------------------
interface rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  a_valid;
    logic [ADDR_WIDTH-1:0] a_rd;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_ready;
    logic                  b_valid;
    logic [ADDR_WIDTH-1:0] b_rd;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_ready;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic                  busy_rs1;
    logic                  busy_rs2;
    logic                  wb_wen;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    modport slave (
        input  a_valid, a_rd, a_data,
        output a_ready,
        input  b_valid, b_rd, b_data,
        output b_ready,
        input  issue_valid, issue_rd, flush, rs1, rs2,
        output busy_rs1, busy_rs2,
        output wb_wen, wb_rd, wb_data
    );

    modport master (
        output a_valid, a_rd, a_data,
        input  a_ready,
        output b_valid, b_rd, b_data,
        input  b_ready,
        output issue_valid, issue_rd, flush, rs1, rs2,
        input  busy_rs1, busy_rs2,
        input  wb_wen, wb_rd, wb_data
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register file write port between writeback sources A and
// B with round-robin arbitration, registers the selected write, and keeps a
// per-register busy scoreboard for RAW hazard detection at issue.
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : synchronous active-low reset
//   bus   : rf_wb_arbiter_if.slave (requests, scoreboard, write port)
// ----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    rf_wb_arbiter_if.slave      bus
);
    localparam int NREGS = 1 << ADDR_WIDTH;

    logic                  last_b_q, last_b_d;
    logic                  wb_wen_q, wb_wen_d;
    logic [ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [NREGS-1:0]      busy_q, busy_d;

    logic                  a_grant, b_grant;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    // Round-robin grant; last_b_q=1 means A has priority on a contest.
    always_comb begin
        a_grant  = 1'b0;
        b_grant  = 1'b0;
        sel_rd   = bus.a_rd;
        sel_data = bus.a_data;
        if (rst_n) begin
            if (bus.a_valid && (!bus.b_valid || last_b_q)) begin
                a_grant = 1'b1;
            end else if (bus.b_valid) begin
                b_grant = 1'b1;
            end
        end
        if (b_grant) begin
            sel_rd   = bus.b_rd;
            sel_data = bus.b_data;
        end
    end

    // Writeback register and pointer next state. A grant to x0 is consumed
    // but never raises the write enable.
    always_comb begin
        last_b_d  = last_b_q;
        wb_wen_d  = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (a_grant || b_grant) begin
            last_b_d  = b_grant;
            wb_wen_d  = (sel_rd != '0);
            wb_rd_d   = sel_rd;
            wb_data_d = sel_data;
        end
    end

    // Scoreboard next state: flush, then writeback clear, then issue set, so
    // a same-cycle issue always survives.
    always_comb begin
        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else if (wb_wen_q) begin
            busy_d[wb_rd_q] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_b_q  <= 1'b1;
            wb_wen_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            last_b_q  <= last_b_d;
            wb_wen_q  <= wb_wen_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.a_ready  = a_grant;
    assign bus.b_ready  = b_grant;
    // Queries read registered state only; masked while reset is asserted.
    assign bus.busy_rs1 = rst_n & busy_q[bus.rs1];
    assign bus.busy_rs2 = rst_n & busy_q[bus.rs2];
    assign bus.wb_wen   = wb_wen_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    logic clk;
    logic rst_n;

    rf_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bdat;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ea;
        logic        eb;
        logic        e1;
        logic        e2;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    localparam int NV = 20;
    vec_t vec [NV];
    wb_t  exp_q [$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                input logic bv, input logic [4:0] brd, input logic [31:0] bdat,
                                input logic iv, input logic [4:0] ird, input logic fl,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic ea, input logic eb, input logic e1, input logic e2);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.bv = bv; v.brd = brd; v.bdat = bdat;
        v.iv = iv; v.ird = ird; v.fl = fl;
        v.rs1 = rs1; v.rs2 = rs2;
        v.ea = ea; v.eb = eb; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.a_valid     = v.av;
        bus.a_rd        = v.ard;
        bus.a_data      = v.adat;
        bus.b_valid     = v.bv;
        bus.b_rd        = v.brd;
        bus.b_data      = v.bdat;
        bus.issue_valid = v.iv;
        bus.issue_rd    = v.ird;
        bus.flush       = v.fl;
        bus.rs1         = v.rs1;
        bus.rs2         = v.rs2;
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " wb_wen"}, {31'd0, bus.wb_wen}, {31'd0, e.wen});
            if (e.wen) begin
                chk({tag, " wb_rd"}, {27'd0, bus.wb_rd}, {27'd0, e.rd});
                chk({tag, " wb_data"}, bus.wb_data, e.data);
            end
        end
    endtask

    initial begin
        wb_t w;
        // Contention, x0 drop, scoreboard set/clear, collision, flush, rotation.
        vec[0]  = mk(1, 3, 32'h11,  1, 4, 32'h22,  0, 0, 0,  3, 4,   1, 0, 0, 0);
        vec[1]  = mk(1, 3, 32'h11,  1, 4, 32'h22,  0, 0, 0,  3, 4,   0, 1, 0, 0);
        vec[2]  = mk(1, 3, 32'h11,  1, 4, 32'h22,  0, 0, 0,  3, 4,   1, 0, 0, 0);
        vec[3]  = mk(1, 3, 32'h11,  1, 4, 32'h22,  0, 0, 0,  3, 4,   0, 1, 0, 0);
        vec[4]  = mk(1, 0, 32'hDEAD, 0, 0, 0,      0, 0, 0,  3, 4,   1, 0, 0, 0);
        vec[5]  = mk(0, 0, 0,       0, 0, 0,       1, 5, 0,  5, 0,   0, 0, 0, 0);
        vec[6]  = mk(1, 5, 32'h55,  0, 0, 0,       0, 0, 0,  5, 0,   1, 0, 1, 0);
        vec[7]  = mk(0, 0, 0,       0, 0, 0,       0, 0, 0,  5, 0,   0, 0, 1, 0);
        vec[8]  = mk(0, 0, 0,       1, 7, 32'h77,  0, 0, 0,  5, 0,   0, 1, 0, 0);
        vec[9]  = mk(0, 0, 0,       0, 0, 0,       1, 7, 0,  7, 5,   0, 0, 0, 0);
        vec[10] = mk(0, 0, 0,       0, 0, 0,       1, 2, 0,  7, 2,   0, 0, 1, 0);
        vec[11] = mk(0, 0, 0,       0, 0, 0,       1, 9, 0,  2, 9,   0, 0, 1, 0);
        vec[12] = mk(0, 0, 0,       1, 2, 32'h222, 1, 12, 1, 2, 9,   0, 1, 1, 1);
        vec[13] = mk(0, 0, 0,       0, 0, 0,       0, 0, 0,  12, 2,  0, 0, 1, 0);
        vec[14] = mk(1, 8, 32'h88,  1, 10, 32'hAA, 0, 0, 0,  9, 7,   1, 0, 0, 0);
        vec[15] = mk(1, 11, 32'hBB, 1, 10, 32'hAA, 0, 0, 0,  7, 12,  0, 1, 0, 1);
        vec[16] = mk(1, 11, 32'hBB, 1, 13, 32'hCC, 0, 0, 0,  12, 0,  1, 0, 1, 0);
        vec[17] = mk(0, 0, 0,       1, 13, 32'hCC, 1, 0, 0,  0, 12,  0, 1, 0, 1);
        vec[18] = mk(0, 0, 0,       0, 0, 0,       0, 0, 0,  0, 0,   0, 0, 0, 0);
        vec[19] = mk(0, 0, 0,       0, 0, 0,       0, 0, 0,  13, 10, 0, 0, 0, 0);

        // Reset held for two cycles with both requesters valid.
        rst_n = 1'b0;
        drive(mk(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 3, 4, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1; #1;
            chk($sformatf("rst%0d a_ready", i), {31'd0, bus.a_ready}, 32'd0);
            chk($sformatf("rst%0d b_ready", i), {31'd0, bus.b_ready}, 32'd0);
            chk($sformatf("rst%0d busy_rs1", i), {31'd0, bus.busy_rs1}, 32'd0);
            chk($sformatf("rst%0d busy_rs2", i), {31'd0, bus.busy_rs2}, 32'd0);
            chk($sformatf("rst%0d wb_wen", i), {31'd0, bus.wb_wen}, 32'd0);
            chk($sformatf("rst%0d wb_rd", i), {27'd0, bus.wb_rd}, 32'd0);
            chk($sformatf("rst%0d wb_data", i), bus.wb_data, 32'd0);
        end

        w.wen = 1'b0; w.rd = '0; w.data = '0;
        exp_q.push_back(w);

        for (int unsigned k = 0; k < NV; k++) begin
            @(posedge clk); #1;
            rst_n = 1'b1;
            drive(vec[k]);
            #1;
            chk($sformatf("c%0d a_ready", k), {31'd0, bus.a_ready}, {31'd0, vec[k].ea});
            chk($sformatf("c%0d b_ready", k), {31'd0, bus.b_ready}, {31'd0, vec[k].eb});
            chk($sformatf("c%0d busy_rs1", k), {31'd0, bus.busy_rs1}, {31'd0, vec[k].e1});
            chk($sformatf("c%0d busy_rs2", k), {31'd0, bus.busy_rs2}, {31'd0, vec[k].e2});
            check_wb($sformatf("c%0d", k));
            if (vec[k].ea) begin
                w.wen = (vec[k].ard != 5'd0); w.rd = vec[k].ard; w.data = vec[k].adat;
            end else if (vec[k].eb) begin
                w.wen = (vec[k].brd != 5'd0); w.rd = vec[k].brd; w.data = vec[k].bdat;
            end else begin
                w.wen = 1'b0; w.rd = '0; w.data = '0;
            end
            exp_q.push_back(w);
        end

        // Reset mid-transfer: request and issue dropped, busy masked while low.
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(mk(1, 6, 32'h66, 0, 0, 0, 1, 6, 0, 12, 6, 0, 0, 0, 0));
        #1;
        chk("mrst a_ready", {31'd0, bus.a_ready}, 32'd0);
        chk("mrst busy_rs1 masked", {31'd0, bus.busy_rs1}, 32'd0);
        chk("mrst busy_rs2", {31'd0, bus.busy_rs2}, 32'd0);
        check_wb("mrst");

        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 6, 0, 0, 0, 0));
        #1;
        chk("post wb_wen", {31'd0, bus.wb_wen}, 32'd0);
        chk("post wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        chk("post wb_data", bus.wb_data, 32'd0);
        chk("post busy_rs1", {31'd0, bus.busy_rs1}, 32'd0);
        chk("post busy_rs2", {31'd0, bus.busy_rs2}, 32'd0);

        @(posedge clk); #1;
        drive(mk(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 12, 6, 0, 0, 0, 0));
        #1;
        chk("post2 wb_wen", {31'd0, bus.wb_wen}, 32'd0);
        chk("post2 a_ready", {31'd0, bus.a_ready}, 32'd1);
        chk("post2 b_ready", {31'd0, bus.b_ready}, 32'd0);

        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("post3 wb_wen", {31'd0, bus.wb_wen}, 32'd1);
        chk("post3 wb_rd", {27'd0, bus.wb_rd}, 32'd3);
        chk("post3 wb_data", bus.wb_data, 32'h11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port between two writeback sources: port A (ALU/CSR results) and port B (load unit). It arbitrates round-robin and drives the registered write signals (wb_wen/wb_rd/wb_data) into the register file. It also keeps a per-register busy scoreboard so the issue stage can detect RAW hazards on outstanding writes. It sits between the execute/LSU stages and the register file, next to the decoder.

Parameters:
ADDR_WIDTH, 5, register index width; the scoreboard has 2**ADDR_WIDTH entries.
DATA_WIDTH, 32, register data width.

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  synchronous reset, active-low
a_valid  input  1  port A has a writeback request
a_rd  input  ADDR_WIDTH  port A destination register
a_data  input  DATA_WIDTH  port A write data
a_ready  output  1  port A request accepted this cycle
b_valid  input  1  port B has a writeback request
b_rd  input  ADDR_WIDTH  port B destination register
b_data  input  DATA_WIDTH  port B write data
b_ready  output  1  port B request accepted this cycle
issue_valid  input  1  an instruction with a destination issues this cycle
issue_rd  input  ADDR_WIDTH  destination of the issuing instruction
flush  input  1  clear the scoreboard (pipeline redirect)
rs1  input  ADDR_WIDTH  scoreboard query index 1
rs2  input  ADDR_WIDTH  scoreboard query index 2
busy_rs1  output  1  rs1 has an outstanding write
busy_rs2  output  1  rs2 has an outstanding write
wb_wen  output  1  register file write enable
wb_rd  output  ADDR_WIDTH  register file write index
wb_data  output  DATA_WIDTH  register file write data

Behaviour:
- Reset (rst_n=0 at posedge):
  - wb_wen=0, wb_rd=0, wb_data=0.
  - All busy bits cleared.
  - Round-robin pointer last_b=1, so A wins the first contest.
  - While rst_n=0: a_ready=0 and b_ready=0 (combinational), and busy outputs read 0.
  - Reset mid-transfer drops the request with no write. Reset dominates flush, issue and grants.
- Arbitration (combinational):
  - Only A valid: a_ready=1. Only B valid: b_ready=1.
  - Both valid: grant A if last_b=1, else grant B.
  - Never both ready in one cycle. Neither ready when neither is valid.
  - last_b updates on every grant: 1 if B was granted, 0 if A was granted. It holds when there is no grant.
  - Requesters must hold valid/rd/data stable until ready. A transfer occurs when valid&&ready.
- Writeback register:
  - A transfer in cycle N gives wb_wen=1 with that rd/data in cycle N+1. The register file writes at the end of N+1.
  - With no transfer in cycle N, wb_wen=0 in N+1; wb_rd/wb_data hold their previous values.
  - A transfer with rd=0 is accepted (ready=1) but produces wb_wen=0. x0 is never written.
  - Sustained throughput: one write per cycle.
- Scoreboard:
  - busy[r] is set at the posedge ending a cycle with issue_valid=1 and issue_rd=r≠0. issue_rd=0 is ignored.
  - busy[r] is cleared at the posedge ending a cycle with wb_wen=1 and wb_rd=r. The bit therefore drops on the same edge the register file captures the data.
  - Set and clear of the same r in the same cycle: set wins, because the new producer is outstanding.
  - flush=1: all bits cleared at the next edge, except a same-cycle issue set, which still applies.
  - A flush does not cancel accepted or in-flight writebacks; they still write the register file.
- Scoreboard query:
  - busy_rs1=busy[rs1] and busy_rs2=busy[rs2], combinational from registered state. No bypass of same-cycle issue or clear.
  - busy[0] is always 0.
- A writeback to a register that is not busy is legal: the write happens and the scoreboard is unchanged.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, wb_wen=0, busy_rs1=busy_rs2=0. Release -> first contested cycle grants A.
2. Contention: a_valid=b_valid=1 held for 4 cycles with a_rd=3/a_data=0x11, b_rd=4/b_data=0x22 -> grants alternate A,B,A,B; wb_wen=1 every cycle from cycle 2 with wb_rd 3,4,3,4 and data 0x11,0x22,...
3. x0 drop: a_valid=1, a_rd=0, a_data=0xDEAD -> a_ready=1; next cycle wb_wen=0.
4. Scoreboard: issue rd=5; next cycle rs1=5 -> busy_rs1=1. A writes rd=5 -> wb_wen=1 one cycle later, and busy_rs1 stays 1 during that cycle. busy_rs1=0 the cycle after.
5. Set/clear collision: wb_wen=1 with wb_rd=7 in the same cycle as issue_valid=1, issue_rd=7 -> busy[7]=1 afterwards.
6. Flush: busy on regs 2,9; flush=1 together with issue rd=12 and a pending B write to rd=2 -> next cycle only busy[12]=1. The B write still produces wb_wen=1, wb_rd=2.
